// File: rtl/tdm_demux.sv
// Receive side of a TDM link: collects one serial sample per valid cycle into a
// parallel frame, presents complete frames with a strobe, and tracks frame lock.
module tdm_demux #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 2,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_start,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic [CW-1:0]             ch_idx,
    output logic                      locked,
    output logic                      frame_err
);

    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] ONE_CH  = CW'(1);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_ch_idx;
    logic [CHANNELS*WIDTH-1:0]   r_stage;
    logic [CHANNELS*WIDTH-1:0]   r_dout;
    logic                        r_dout_valid;
    logic                        r_locked;
    logic                        r_frame_err;
    logic [CHANNELS*WIDTH-1:0]   w_frame;

    // Staged frame with the current sample merged into its slot, so the final
    // sample of a frame reaches dout in the same edge it is accepted.
    always_comb begin
        // NOTE: full default before the partial write keeps this purely combinational.
        w_frame = r_stage;
        w_frame[int'(r_ch_idx)*WIDTH +: WIDTH] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            r_ch_idx     <= '0;
            r_stage      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; every reg below is sampled pre-edge.
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        if (frame_start) begin
                            r_stage[WIDTH-1:0] <= din;
                            r_ch_idx           <= ONE_CH;
                            r_state            <= COLLECT;
                        end else if (r_locked) begin
                            r_frame_err <= 1'b1;
                            r_locked    <= 1'b0;
                        end
                    end
                    COLLECT: begin
                        if (frame_start) begin
                            // Premature start: drop the partial frame and restart at slot 0.
                            r_frame_err        <= 1'b1;
                            r_locked           <= 1'b0;
                            r_stage[WIDTH-1:0] <= din;
                            r_ch_idx           <= ONE_CH;
                        end else begin
                            r_stage <= w_frame;
                            if (r_ch_idx == LAST_CH) begin
                                r_dout       <= w_frame;
                                r_dout_valid <= 1'b1;
                                r_locked     <= 1'b1;
                                r_ch_idx     <= '0;
                                r_state      <= HUNT;
                            end else begin
                                r_ch_idx <= r_ch_idx + ONE_CH;
                            end
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign ch_idx     = r_ch_idx;
    assign locked     = r_locked;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a vector table on the default 2x1 build and
// hand-written sequences on a 4x8 build for gaps and mid-frame reset.
module tb_tdm_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default build: CHANNELS=2, WIDTH=1
    logic       rst2, v2, fs2;
    logic [0:0] din2;
    logic [1:0] dout2;
    logic       dv2, lk2, err2;
    logic [0:0] ch2;

    tdm_demux u_d2 (
        .clk(clk), .rst(rst2), .din(din2), .din_valid(v2), .frame_start(fs2),
        .dout(dout2), .dout_valid(dv2), .ch_idx(ch2), .locked(lk2), .frame_err(err2)
    );

    // Wide build: CHANNELS=4, WIDTH=8
    logic        rst4, v4, fs4;
    logic [7:0]  din4;
    logic [31:0] dout4;
    logic        dv4, lk4, err4;
    logic [1:0]  ch4;

    tdm_demux #(.WIDTH(8), .CHANNELS(4)) u_d4 (
        .clk(clk), .rst(rst4), .din(din4), .din_valid(v4), .frame_start(fs4),
        .dout(dout4), .dout_valid(dv4), .ch_idx(ch4), .locked(lk4), .frame_err(err4)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic       rst;
        logic       v;
        logic       fs;
        logic       din;
        logic [1:0] e_dout;
        logic       e_dv;
        logic       e_ch;
        logic       e_lk;
        logic       e_err;
    } vec_t;

    vec_t tbl[18];

    // Apply one cycle to the wide build and check every output after the edge.
    task automatic step4(input string name, input logic rst, input logic v, input logic fs,
                         input logic [7:0] d, input logic [31:0] e_dout, input logic e_dv,
                         input logic [1:0] e_ch, input logic e_lk, input logic e_err);
        rst4 = rst; v4 = v; fs4 = fs; din4 = d;
        @(posedge clk); #1;
        check(name, 64'({dout4, dv4, ch4, lk4, err4}), 64'({e_dout, e_dv, e_ch, e_lk, e_err}));
    endtask

    initial begin
        //          name             rst v  fs din  dout   dv ch lk err
        tbl[0]  = '{"rst_a",         1, 1, 1, 1, 2'b00, 0, 0, 0, 0};
        tbl[1]  = '{"rst_b",         1, 1, 1, 1, 2'b00, 0, 0, 0, 0};
        tbl[2]  = '{"f1_s0",         0, 1, 1, 0, 2'b00, 0, 1, 0, 0};
        tbl[3]  = '{"f1_s1",         0, 1, 0, 1, 2'b10, 1, 0, 1, 0};
        tbl[4]  = '{"f1_dv_drop",    0, 0, 0, 0, 2'b10, 0, 0, 1, 0};
        tbl[5]  = '{"f2_s0",         0, 1, 1, 1, 2'b10, 0, 1, 1, 0};
        tbl[6]  = '{"f2_s1",         0, 1, 0, 0, 2'b01, 1, 0, 1, 0};
        tbl[7]  = '{"pre_s0",        0, 1, 1, 1, 2'b01, 0, 1, 1, 0};
        tbl[8]  = '{"pre_restart",   0, 1, 1, 0, 2'b01, 0, 1, 0, 1};
        tbl[9]  = '{"pre_done",      0, 1, 0, 1, 2'b10, 1, 0, 1, 0};
        tbl[10] = '{"lost_idle",     0, 0, 0, 0, 2'b10, 0, 0, 1, 0};
        tbl[11] = '{"lost_err",      0, 1, 0, 1, 2'b10, 0, 0, 0, 1};
        tbl[12] = '{"lost_quiet",    0, 1, 0, 0, 2'b10, 0, 0, 0, 0};
        tbl[13] = '{"rst_again",     1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        tbl[14] = '{"post_rst_nofs", 0, 1, 0, 1, 2'b00, 0, 0, 0, 0};
        tbl[15] = '{"fsig_s0",       0, 1, 1, 1, 2'b00, 0, 1, 0, 0};
        tbl[16] = '{"fs_no_valid",   0, 0, 1, 0, 2'b00, 0, 1, 0, 0};
        tbl[17] = '{"fsig_done",     0, 1, 0, 1, 2'b11, 1, 0, 1, 0};

        rst4 = 1'b1; v4 = 1'b0; fs4 = 1'b0; din4 = '0;

        for (int i = 0; i < 18; i++) begin
            rst2 = tbl[i].rst; v2 = tbl[i].v; fs2 = tbl[i].fs; din2 = tbl[i].din;
            @(posedge clk); #1;
            check(tbl[i].name, 64'({dout2, dv2, ch2, lk2, err2}),
                  64'({tbl[i].e_dout, tbl[i].e_dv, tbl[i].e_ch, tbl[i].e_lk, tbl[i].e_err}));
        end
        rst2 = 1'b0; v2 = 1'b0; fs2 = 1'b0; din2 = '0;

        // Gaps inside a frame on the wide build
        step4("w_rst",   1, 1, 1, 8'hEE, 32'h0,        0, 2'd0, 0, 0);
        step4("w_s0",    0, 1, 1, 8'hA5, 32'h0,        0, 2'd1, 0, 0);
        step4("w_s1",    0, 1, 0, 8'h3C, 32'h0,        0, 2'd2, 0, 0);
        for (int g = 0; g < 3; g++)
            step4("w_gap", 0, 0, 0, 8'hFF, 32'h0,      0, 2'd2, 0, 0);
        step4("w_s2",    0, 1, 0, 8'h0F, 32'h0,        0, 2'd3, 0, 0);
        step4("w_s3",    0, 1, 0, 8'hF0, 32'hF00F3CA5, 1, 2'd0, 1, 0);
        step4("w_hold",  0, 0, 0, 8'h00, 32'hF00F3CA5, 0, 2'd0, 1, 0);

        // Reset in the middle of a frame, then a clean frame
        step4("m_s0",    0, 1, 1, 8'h11, 32'hF00F3CA5, 0, 2'd1, 1, 0);
        step4("m_s1",    0, 1, 0, 8'h22, 32'hF00F3CA5, 0, 2'd2, 1, 0);
        step4("m_rst",   1, 0, 0, 8'h00, 32'h0,        0, 2'd0, 0, 0);
        step4("m_f0",    0, 1, 1, 8'h01, 32'h0,        0, 2'd1, 0, 0);
        step4("m_f1",    0, 1, 0, 8'h02, 32'h0,        0, 2'd2, 0, 0);
        step4("m_f2",    0, 1, 0, 8'h03, 32'h0,        0, 2'd3, 0, 0);
        step4("m_f3",    0, 1, 0, 8'h04, 32'h04030201, 1, 2'd0, 1, 0);
        step4("m_after", 0, 0, 0, 8'h00, 32'h04030201, 0, 2'd0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
